// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path.
// Opcodes, ALU codes, FSM states and branch conditions.
package cpu_pkg;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BR   = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] ALU_ADD    = 4'h0;
    localparam logic [3:0] ALU_PASS_T = 4'hF;

    localparam logic [3:0] BR_AL = 4'h0;
    localparam logic [3:0] BR_Z  = 4'h1;
    localparam logic [3:0] BR_NZ = 4'h2;
    localparam logic [3:0] BR_C  = 4'h3;
    localparam logic [3:0] BR_NC = 4'h4;
    localparam logic [3:0] BR_N  = 4'h5;
    localparam logic [3:0] BR_NN = 4'h6;
    localparam logic [3:0] BR_V  = 4'h7;
    localparam logic [3:0] BR_NV = 4'h8;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic v;
    } flags_t;

    function automatic logic [15:0] sext4(input logic [3:0] x);
        return {{12{x[3]}}, x};
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] x);
        return {{8{x[7]}}, x};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] x);
        return {{4{x[11]}}, x};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator.
// Maps a 4-bit condition code and latched flags to taken.
import cpu_pkg::*;

module branch_cond (
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       taken
);

    // Codes 9..15 are reserved and never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_AL:   taken = 1'b1;
            BR_Z:    taken = flags.z;
            BR_NZ:   taken = ~flags.z;
            BR_C:    taken = flags.c;
            BR_NC:   taken = ~flags.c;
            BR_N:    taken = flags.n;
            BR_NN:   taken = ~flags.n;
            BR_V:    taken = flags.v;
            BR_NV:   taken = ~flags.v;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute controller.
// Owns PC, IR, flags and the shared memory port.
import cpu_pkg::*;

module control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        fZ,
    input  logic        fC,
    input  logic        fN,
    input  logic        fV,
    input  logic [15:0] rout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        wen,
    output logic [3:0]  selRd,
    output logic [3:0]  selRs,
    output logic [3:0]  selRt,
    output logic [3:0]  aluOp,
    output logic [15:0] t,
    output logic        selT,
    output logic        halted,
    output logic [15:0] pc
);

    state_t      state;
    state_t      nxt;
    logic [15:0] ir;
    logic [15:0] addr;
    logic [15:0] ldata;
    flags_t      flg;
    logic        taken;

    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [7:0]  imm8;
    logic [11:0] imm12;

    logic        is_rtype;
    logic        is_ldi;
    logic        is_addi;
    logic        is_mem;
    logic        is_st;
    logic        is_hlt;

    assign op    = ir[15:12];
    assign rd    = ir[11:8];
    assign rs    = ir[7:4];
    assign rt    = ir[3:0];
    assign imm8  = ir[7:0];
    assign imm12 = ir[11:0];

    assign is_rtype = ~op[3];
    assign is_ldi   = (op == OP_LDI);
    assign is_addi  = (op == OP_ADDI);
    assign is_mem   = (op == OP_LD) || (op == OP_ST);
    assign is_st    = (op == OP_ST);
    assign is_hlt   = (op == OP_HLT);

    branch_cond u_br (
        .cond  (rd),
        .flags (flg),
        .taken (taken)
    );

    // Architectural state: FSM, PC, IR, flags, LD/ST address, load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            flg   <= '0;
            addr  <= '0;
            ldata <= '0;
        end else begin
            state <= nxt;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (is_rtype || is_addi)
                        flg <= '{z: fZ, c: fC, n: fN, v: fV};
                    if (op == OP_JMP)
                        pc <= pc + sext12(imm12);
                    if (op == OP_BR && taken)
                        pc <= pc + sext8(imm8);
                    if (op == OP_JR)
                        pc <= rout;
                    if (is_mem)
                        addr <= rout;
                end
                S_MEM: begin
                    if (mem_ack && !is_st)
                        ldata <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Next state and datapath/memory controls; all quiet while in reset.
    always_comb begin
        nxt       = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        wen       = 1'b0;
        selRd     = rd;
        selRs     = rs;
        selRt     = rt;
        aluOp     = ALU_ADD;
        t         = '0;
        selT      = 1'b0;
        halted    = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack)
                        nxt = S_DECODE;
                end
                S_DECODE: nxt = S_EXEC;
                S_EXEC: begin
                    nxt = S_FETCH;
                    unique case (1'b1)
                        is_rtype: begin
                            wen   = 1'b1;
                            aluOp = {1'b0, op[2:0]};
                        end
                        is_ldi: begin
                            wen   = 1'b1;
                            selT  = 1'b1;
                            t     = {8'h00, imm8};
                            aluOp = ALU_PASS_T;
                        end
                        is_addi: begin
                            wen  = 1'b1;
                            selT = 1'b1;
                            t    = sext4(rt);
                        end
                        is_mem: nxt = S_MEM;
                        is_hlt: nxt = S_HALT;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = addr;
                    if (is_st) begin
                        mem_we    = 1'b1;
                        selRs     = rd;
                        mem_wdata = rout;
                    end
                    if (mem_ack)
                        nxt = is_st ? S_FETCH : S_WB;
                end
                S_WB: begin
                    wen   = 1'b1;
                    selT  = 1'b1;
                    t     = ldata;
                    aluOp = ALU_PASS_T;
                    nxt   = S_FETCH;
                end
                S_HALT: halted = 1'b1;
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural datapath/memory plus
// an instruction-level reference model compared event by event.
module tb_control_unit;

    localparam logic [15:0] RPC = 16'h0010;

    localparam logic [1:0] EV_RD = 2'd0;
    localparam logic [1:0] EV_WR = 2'd1;
    localparam logic [1:0] EV_RW = 2'd2;

    typedef struct packed {
        logic [1:0]  k;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        fZ, fC, fN, fV;
    logic [15:0] rout;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        wen;
    logic [3:0]  selRd, selRs, selRt, aluOp;
    logic [15:0] t;
    logic        selT, halted;
    logic [15:0] pc;

    logic [15:0] mem  [65536];
    logic [15:0] mmem [65536];
    logic [15:0] dregs [16];
    logic [15:0] alu_res;
    int          mode = 0;
    int          wcnt;
    int          cur_wait;

    int          total = 0;
    int          passed = 0;
    int          cyc;
    int          first_wen;
    int          halt_cyc;
    logic [3:0]  sn_rd, sn_op;
    logic        sn_selt;
    logic [15:0] sn_t;

    logic [15:0] mpc;
    logic [15:0] mregs [16];
    logic [3:0]  mflags;
    bit          mhalt;
    int          exp_cyc;
    ev_t         exp_q [$];

    control_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fZ(fZ), .fC(fC), .fN(fN), .fV(fV),
        .rout(rout),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .wen(wen), .selRd(selRd), .selRs(selRs), .selRt(selRt),
        .aluOp(aluOp), .t(t), .selT(selT),
        .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    // Bench ALU: add, sub, and, or, xor, shl, shr, not; others pass b.
    function automatic logic [19:0] alu(input logic [3:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        logic [16:0] w;
        logic [15:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[15:0];
                c = w[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'h1: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: begin r = a << 1; c = a[15]; end
            4'h6: begin r = a >> 1; c = a[0]; end
            4'h7: r = ~a;
            default: r = b;
        endcase
        return {(r == 16'h0), c, r[15], v, r};
    endfunction

    assign rout = dregs[selRs];
    assign {fZ, fC, fN, fV, alu_res} =
        alu(aluOp, dregs[selRs], selT ? t : dregs[selRt]);
    assign mem_rdata = mem[mem_addr];
    assign mem_ack = mem_req && (wcnt >= cur_wait);

    function automatic int pick_wait(input int m);
        if (m == 0) return 0;
        if (m == 1) return 3;
        return int'($urandom_range(0, 3));
    endfunction

    // Register file of the modelled datapath.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) dregs[i] <= '0;
        end else if (wen) begin
            dregs[selRd] <= alu_res;
        end
    end

    // Memory wait-state generator.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt     <= 0;
            cur_wait <= pick_wait(mode);
        end else if (mem_req) begin
            if (mem_ack) begin
                wcnt     <= 0;
                cur_wait <= pick_wait(mode);
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    function automatic ev_t mk(input logic [1:0] k,
                               input logic [15:0] a,
                               input logic [15:0] d);
        ev_t e;
        e.k = k;
        e.a = a;
        e.d = d;
        return e;
    endfunction

    function automatic bit br_taken(input logic [3:0] cc,
                                    input logic [3:0] f);
        bit z, c, n, v;
        {z, c, n, v} = f;
        case (cc)
            4'd0: return 1'b1;
            4'd1: return z;
            4'd2: return !z;
            4'd3: return c;
            4'd4: return !c;
            4'd5: return n;
            4'd6: return !n;
            4'd7: return v;
            4'd8: return !v;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One instruction at ISA level; queues its visible effects.
    task automatic model_step();
        logic [15:0] ir, a;
        logic [19:0] x;
        logic [3:0]  op, rd, rs, rt;
        int          w;
        w = (mode == 1) ? 3 : 0;
        exp_q.push_back(mk(EV_RD, mpc, 16'h0));
        ir = mmem[mpc];
        mpc = mpc + 16'd1;
        {op, rd, rs, rt} = ir;
        exp_cyc += 3 + w;
        if (op < 4'h8) begin
            x = alu(op, mregs[rs], mregs[rt]);
            mregs[rd] = x[15:0];
            mflags = x[19:16];
            exp_q.push_back(mk(EV_RW, {12'h0, rd}, x[15:0]));
        end else begin
            case (op)
                4'h8: begin
                    mregs[rd] = {8'h00, ir[7:0]};
                    exp_q.push_back(mk(EV_RW, {12'h0, rd}, mregs[rd]));
                end
                4'h9: begin
                    x = alu(4'h0, mregs[rs], {{12{rt[3]}}, rt});
                    mregs[rd] = x[15:0];
                    mflags = x[19:16];
                    exp_q.push_back(mk(EV_RW, {12'h0, rd}, x[15:0]));
                end
                4'hA: begin
                    a = mregs[rs];
                    exp_q.push_back(mk(EV_RD, a, 16'h0));
                    mregs[rd] = mmem[a];
                    exp_q.push_back(mk(EV_RW, {12'h0, rd}, mregs[rd]));
                    exp_cyc += 2 + w;
                end
                4'hB: begin
                    a = mregs[rs];
                    exp_q.push_back(mk(EV_WR, a, mregs[rd]));
                    mmem[a] = mregs[rd];
                    exp_cyc += 1 + w;
                end
                4'hC: mpc = mpc + {{4{ir[11]}}, ir[11:0]};
                4'hD: if (br_taken(rd, mflags))
                          mpc = mpc + {{8{ir[7]}}, ir[7:0]};
                4'hE: mpc = mregs[rs];
                default: mhalt = 1'b1;
            endcase
        end
    endtask

    task automatic observe(input ev_t e);
        ev_t x;
        if (exp_q.size() == 0 && !mhalt) model_step();
        if (exp_q.size() == 0) begin
            chk("unexpected_event", 40'(e), 40'h0);
        end else begin
            x = exp_q.pop_front();
            chk("event", 40'(e), 40'(x));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (wen && first_wen == 0) begin
            first_wen = cyc;
            sn_rd     = selRd;
            sn_selt   = selT;
            sn_t      = t;
            sn_op     = aluOp;
        end
        if (halted && halt_cyc == 0) halt_cyc = cyc;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                observe(mk(EV_WR, mem_addr, mem_wdata));
                mem[mem_addr] = mem_wdata;
            end else begin
                observe(mk(EV_RD, mem_addr, 16'h0));
            end
        end
        if (wen) observe(mk(EV_RW, {12'h0, selRd}, alu_res));
    endtask

    task automatic start(input int m);
        mode = m;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        mpc = RPC;
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        mflags = '0;
        mhalt = 1'b0;
        exp_q.delete();
        exp_cyc = 0;
        mmem = mem;
        cyc = 0;
        first_wen = 0;
        halt_cyc = 0;
        #1;
        chk("in_reset", 40'({mem_req, wen, halted, pc}),
            40'({3'b000, RPC}));
        @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        chk("first_req", 40'({mem_req, mem_we, wen, mem_addr}),
            40'({3'b100, RPC}));
    endtask

    task automatic run_prog(input int m, input int budget, input bit lat);
        start(m);
        while (!halted && cyc < budget) cycle();
        chk("halt_match", 40'(halted), 40'(mhalt));
        if (halted) begin
            chk("queue_drained", 40'(exp_q.size()), 40'd0);
            chk("halt_pc", 40'(pc), 40'(mpc));
        end
        if (lat) chk("halt_latency", 40'(halt_cyc), 40'(exp_cyc + 1));
    endtask

    task automatic load_directed();
        logic [15:0] prog [16];
        prog = '{16'h817F, 16'h0711, 16'h1211, 16'hD101,
                 16'hF000, 16'h8402, 16'h944F, 16'hD2FE,
                 16'h8540, 16'h86AB, 16'hB650, 16'hA350,
                 16'h871F, 16'hE070, 16'hF000, 16'hC800};
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
        for (int i = 0; i < 16; i++) mem[RPC + 16'(i)] = prog[i];
    endtask

    initial begin
        int bad;

        load_directed();
        run_prog(0, 500, 1'b1);
        chk("ldi_wen_cycle", 40'(first_wen), 40'd3);
        chk("ldi_ctrl", 40'({sn_rd, sn_selt, sn_op, sn_t}),
            40'({4'd1, 1'b1, 4'hF, 16'h007F}));
        chk("ld_result", 40'(mregs[3]), 40'h00AB);
        chk("final_pc", 40'(pc), 40'hF821);
        bad = 0;
        repeat (20) begin
            cycle();
            if (mem_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        chk("halt_hold", 40'(bad), 40'd0);

        load_directed();
        start(1);
        chk("fetch_wait_req", 40'({mem_req, mem_ack}), 40'b10);
        rst = 1'b0;
        #1;
        chk("reset_drops_req", 40'({mem_req, wen, pc}),
            40'({2'b00, RPC}));

        load_directed();
        run_prog(1, 1000, 1'b1);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
            run_prog((r % 2 == 0) ? 2 : 1, 2000, r % 2 == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
